// File: rtl/odd_cnt_arb_pkg.sv
// odd_cnt_arb_pkg: shared FSM encoding and default sizing for the odd-counter arbiter.
package odd_cnt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/odd_cnt_core.sv
// odd_cnt_core: WIDTH-bit odd-number generator, starts at 1 and steps by 2 per enabled edge.
module odd_cnt_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] cnt_o
);

    // Natural modulo wrap keeps bit 0 set, so 2^WIDTH-1 rolls to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_o <= WIDTH'(1);
        else if (en)
            cnt_o <= cnt_o + WIDTH'(2);
    end

endmodule

// File: rtl/odd_cnt_arbiter.sv
// odd_cnt_arbiter: round-robin arbiter sharing one odd-number generator among NREQ requesters,
// bounded bursts of MAX_BURST beats with a one-cycle turnaround gap between grants.
module odd_cnt_arbiter
    import odd_cnt_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] cnt_o,
    output logic             busy_o
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    state_t        state, nxt;
    logic [OW-1:0] last_owner, pick, idx, nxt_owner;
    logic [BW-1:0] beat;
    logic          last_beat;

    // Scan from farthest to nearest so the requester right after last_owner wins.
    always_comb begin
        pick = last_owner;
        idx  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = OW'((int'(last_owner) + k) % NREQ);
            if (req_i[idx])
                pick = idx;
        end
    end

    assign last_beat = beat == BW'(MAX_BURST - 1);
    assign nxt_owner = (state == GRANT) ? last_owner : pick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= OW'(NREQ - 1);
            beat       <= '0;
            gnt_o      <= '0;
        end else begin
            state      <= nxt;
            gnt_o      <= (nxt == GRANT) ? NREQ'(1) << nxt_owner : '0;
            last_owner <= (nxt == GRANT) ? nxt_owner : last_owner;
            beat       <= (state != GRANT) ? '0 : (valid_o ? beat + BW'(1) : beat);
        end
    end

    always_comb begin
        nxt = (state == GRANT) ? ((!req_i[last_owner] || last_beat) ? GAP : GRANT)
                               : (|req_i ? GRANT : IDLE);
    end

    always_comb begin
        valid_o = (state == GRANT) && req_i[last_owner];
        busy_o  = state != IDLE;
    end

    odd_cnt_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .reset (reset),
        .en    (valid_o),
        .cnt_o (cnt_o)
    );

endmodule

// File: tb/tb_odd_cnt_arbiter.sv
// tb_odd_cnt_arbiter: directed scoreboard bench; expected beats are queued as stimulus is applied
// and popped whenever the arbiter presents a valid beat.
module tb_odd_cnt_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] cnt;
    } beat_t;

    logic       clk;
    logic       reset;
    logic [3:0] req_i;
    logic [3:0] gnt_o;
    logic       valid_o;
    logic [7:0] cnt_o;
    logic       busy_o;

    beat_t      sb[$];
    logic [7:0] model;
    int         checks = 0;
    int         errors = 0;

    odd_cnt_arbiter #(.NREQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req_i   (req_i),
        .gnt_o   (gnt_o),
        .valid_o (valid_o),
        .cnt_o   (cnt_o),
        .busy_o  (busy_o)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input int o, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{gnt: 4'(1) << o, cnt: model});
            model = model + 8'd2;
        end
    endtask

    // Sample mid-cycle: valid_o here is the beat taken at the coming rising edge.
    task automatic tick();
        beat_t e;
        @(negedge clk);
        checks++;
        assert ($onehot0(gnt_o)) else begin
            errors++;
            $error("FAIL gnt_onehot observed=%b expected at most one bit", gnt_o);
        end
        if (valid_o) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_beat observed cnt=%0d gnt=%b expected no beat", cnt_o, gnt_o);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("beat_cnt", 32'(cnt_o), 32'(e.cnt));
                chk("beat_gnt", 32'(gnt_o), 32'(e.gnt));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int budget);
        int t = 0;
        while (sb.size() != 0 && t < budget) begin
            tick();
            t++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        reset = 1'b1;
        req_i = 4'b0000;
        model = 8'd1;
        repeat (5) begin
            tick();
            chk("rst_gnt", 32'(gnt_o), 32'd0);
            chk("rst_valid", 32'(valid_o), 32'd0);
            chk("rst_cnt", 32'(cnt_o), 32'd1);
            chk("rst_busy", 32'(busy_o), 32'd0);
        end
        reset = 1'b0;
        req_i = 4'b0001;
        push_burst(0, 4);
        tick();
        chk("first_grant", 32'(gnt_o), 32'b0001);
        chk("first_busy", 32'(busy_o), 32'd1);
        run(20);
        chk("gap_gnt", 32'(gnt_o), 32'd0);
        chk("gap_busy", 32'(busy_o), 32'd1);
        chk("gap_valid", 32'(valid_o), 32'd0);
        chk("gap_cnt", 32'(cnt_o), 32'd9);
        push_burst(0, 4);
        run(20);
        repeat (30) push_burst(0, 4);
        push_burst(0, 3);
        run(400);
        chk("pre_rst_cnt", 32'(cnt_o), 32'd7);
        reset = 1'b1;
        req_i = 4'b1111;
        model = 8'd1;
        #1;
        chk("midrst_gnt", 32'(gnt_o), 32'd0);
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_cnt", 32'(cnt_o), 32'd1);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        tick();
        reset = 1'b0;
        for (int o = 0; o < 5; o++)
            push_burst(o % 4, 4);
        run(60);
        reset = 1'b1;
        req_i = 4'b0010;
        model = 8'd1;
        tick();
        reset = 1'b0;
        push_burst(1, 2);
        run(10);
        req_i = 4'b0100;
        tick();
        chk("drop_gap_gnt", 32'(gnt_o), 32'd0);
        chk("drop_gap_busy", 32'(busy_o), 32'd1);
        chk("drop_hold_cnt", 32'(cnt_o), 32'd5);
        push_burst(2, 4);
        run(20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
